serial_mod_detector: RTL and testbench
======================================

SERIAL_MOD_DETECTOR -- requirements
Module: serial_mod_detector

Interface
REQ-001 SHALL have parameter DIVISOR, default 4: modulus tested, legal range 1..256.
REQ-002 SHALL have parameter CNT_W, default 8: width of bit and hit counters.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port a, input, 1 bit: serial data bit, MSB first.
REQ-006 SHALL have port valid, input, 1 bit: a is sampled only when valid=1.
REQ-007 SHALL have port start, input, 1 bit: begins a new number, with or without valid.
REQ-008 SHALL have port y, output, 1 bit: registered Moore flag, number so far ≡ 0 mod DIVISOR.
REQ-009 SHALL have port rem, output, RW=max(1,clog2(DIVISOR)) bits: current remainder.
REQ-010 SHALL have port hit, output, 1 bit: one-cycle pulse, accepted bit produced remainder 0.
REQ-011 SHALL have port nbits, output, CNT_W bits: bits accepted in current number, saturating.

Function
REQ-012 SHALL, on valid=1 and start=0: rem <= (2*rem + a) mod DIVISOR; seen <= 1; nbits <= nbits+1, saturating.
REQ-013 SHALL, on valid=1 and start=1: rem <= a mod DIVISOR; seen <= 1; nbits <= 1 (bit is the MSB of the new number).
REQ-014 SHALL, on start=1 and valid=0: rem <= 0; seen <= 0; nbits <= 0.
REQ-015 SHALL hold all state when valid=0 and start=0.
REQ-016 SHALL drive y = seen AND (rem==0) from registers only; latency is one edge from bit sample to y.
REQ-017 SHALL assert hit for exactly the cycle after each accepted bit whose new remainder is 0, including repeated zeros.
REQ-018 SHALL compute the step without a divider: 2*rem+a < 2*DIVISOR, so at most one conditional subtract of DIVISOR.
REQ-019 SHALL, for DIVISOR=1, keep rem=0 and assert y whenever seen=1.
REQ-020 SHALL hold nbits at 2^CNT_W-1 once reached; remainder tracking continues unaffected.
REQ-021 SHALL fail elaboration when DIVISOR is outside 1..256.
REQ-022 SHALL drive X-free outputs for any input sequence after the first reset.

Reset
REQ-023 SHALL, on rst=1 at a clock edge: rem=0, seen=0, y=0, hit=0, nbits=0, hit_cnt=0; rst dominates start/valid.
REQ-024 SHALL discard a partially received number on mid-stream reset; the next accepted bit starts a fresh number.

Configuration
REQ-025 SHALL, with SERIAL_MOD_HIT_CNT_EN defined, add output hit_cnt (CNT_W bits) counting hit pulses since reset, saturating, not cleared by start.
REQ-026 SHALL, without SERIAL_MOD_HIT_CNT_EN, omit hit_cnt port and logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place the rem-width function, DIVISOR limits (1, 256) and CNT_W default in package serial_mod_pkg.
REQ-028 SHALL isolate the remainder step (2*rem+a, conditional subtract) in combinational sub-module serial_mod_step; the counters and flags stay in the top module.

Verification
REQ-029 SHALL test DIVISOR=4 with start+1, 1, 0, 0 (12): rem 1,3,2,0; y=1 and hit=1 only after 4th bit; nbits=4.
REQ-030 SHALL test DIVISOR=3 with 1, 1, 0 (6): rem 1,0,0; hit pulses after bits 2 and 3; y stays 1.
REQ-031 SHALL test DIVISOR=5 with 1, 0, 1, 0 and valid gaps of 3 idle cycles between bits: rem 1,2,0,0 with no change during gaps.
REQ-032 SHALL test rst after 2 bits of a DIVISOR=4 stream: next cycle all outputs 0; bits 0, 0 then give seen=1, y=1, nbits=2.
REQ-033 SHALL test CNT_W=2 with 5 accepted bits: nbits saturates at 3; rem stays correct.
REQ-034 SHALL test with SERIAL_MOD_HIT_CNT_EN defined, DIVISOR=2, stream 0,0,1,0 across a start: hit_cnt=3 and not cleared by start.

Source files
------------

// File: rtl/serial_mod_pkg.sv
// Shared constants and helpers for the serial modulus detector.
// Remainder width is max(1, clog2(DIVISOR)).
package serial_mod_pkg;

  localparam int DIVISOR_MIN   = 1;
  localparam int DIVISOR_MAX   = 256;
  localparam int CNT_W_DEFAULT = 8;

  function automatic int rem_width(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/serial_mod_step.sv
// Combinational remainder step: (2*rem + a) mod DIVISOR.
// Because 2*rem + a < 2*DIVISOR, a single conditional subtract replaces a divider.
module serial_mod_step
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR = 4,
  localparam int RW = rem_width(DIVISOR)
) (
  input  logic [RW-1:0] rem_in,
  input  logic          a,
  output logic [RW-1:0] rem_out
);

  localparam int DW = RW + 1;
  localparam logic [RW:0] DIV_V = DW'(DIVISOR);

  logic [RW:0] dbl;
  logic [RW:0] diff;

  always_comb begin
    dbl     = {rem_in, a};
    diff    = dbl - DIV_V;
    rem_out = (dbl >= DIV_V) ? diff[RW-1:0] : dbl[RW-1:0];
  end

endmodule

// File: rtl/serial_mod_detector.sv
// Serial MSB-first divisibility detector with remainder, hit pulse and bit counter.
// Optional hit counter output enabled by defining SERIAL_MOD_HIT_CNT_EN.
module serial_mod_detector
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR = 4,
  parameter int CNT_W   = CNT_W_DEFAULT,
  localparam int RW = rem_width(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             valid,
  input  logic             start,
  output logic             y,
  output logic [RW-1:0]    rem,
  output logic             hit,
  output logic [CNT_W-1:0] nbits
`ifdef SERIAL_MOD_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
    $error("serial_mod_detector: DIVISOR out of range 1..256");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic          seen;
  logic [RW-1:0] rem_base;
  logic [RW-1:0] rem_next;

  // A start with a valid bit treats that bit as the MSB of a fresh number.
  always_comb begin
    rem_base = start ? '0 : rem;
  end

  serial_mod_step #(.DIVISOR(DIVISOR)) u_step (
    .rem_in  (rem_base),
    .a       (a),
    .rem_out (rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      seen  <= 1'b0;
      hit   <= 1'b0;
      nbits <= '0;
    end else begin
      hit <= 1'b0;
      if (valid) begin
        rem   <= rem_next;
        seen  <= 1'b1;
        nbits <= start ? CNT_W'(1) : sat_inc(nbits);
        hit   <= (rem_next == '0);
      end else if (start) begin
        rem   <= '0;
        seen  <= 1'b0;
        nbits <= '0;
      end
    end
  end

`ifdef SERIAL_MOD_HIT_CNT_EN
  // Counts every issued hit since reset; start does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (valid && (rem_next == '0)) begin
      hit_cnt <= sat_inc(hit_cnt);
    end
  end
`endif

  always_comb begin
    y = seen && (rem == '0);
  end

endmodule

// File: tb/tb_serial_mod_detector.sv
// Directed bench for serial_mod_detector: several DIVISOR/CNT_W instances share
// one stimulus stream; each task checks the instance it targets.
module tb_serial_mod_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic valid = 1'b0;
  logic start = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic       d4_y, d4_hit;  logic [1:0] d4_rem;  logic [7:0] d4_nb;
  logic       d3_y, d3_hit;  logic [1:0] d3_rem;  logic [7:0] d3_nb;
  logic       d5_y, d5_hit;  logic [2:0] d5_rem;  logic [7:0] d5_nb;
  logic       s_y, s_hit;    logic [1:0] s_rem;   logic [1:0] s_nb;
  logic       d2_y, d2_hit;  logic [0:0] d2_rem;  logic [7:0] d2_nb;
  logic       d1_y, d1_hit;  logic [0:0] d1_rem;  logic [7:0] d1_nb;
`ifdef SERIAL_MOD_HIT_CNT_EN
  logic [7:0] d4_hc, d3_hc, d5_hc, d2_hc, d1_hc;
  logic [1:0] s_hc;
`endif

  serial_mod_detector #(.DIVISOR(4), .CNT_W(8)) u_d4 (
    .clk(clk), .rst(rst), .a(a), .valid(valid), .start(start),
    .y(d4_y), .rem(d4_rem), .hit(d4_hit), .nbits(d4_nb)
`ifdef SERIAL_MOD_HIT_CNT_EN
    , .hit_cnt(d4_hc)
`endif
  );
  serial_mod_detector #(.DIVISOR(3), .CNT_W(8)) u_d3 (
    .clk(clk), .rst(rst), .a(a), .valid(valid), .start(start),
    .y(d3_y), .rem(d3_rem), .hit(d3_hit), .nbits(d3_nb)
`ifdef SERIAL_MOD_HIT_CNT_EN
    , .hit_cnt(d3_hc)
`endif
  );
  serial_mod_detector #(.DIVISOR(5), .CNT_W(8)) u_d5 (
    .clk(clk), .rst(rst), .a(a), .valid(valid), .start(start),
    .y(d5_y), .rem(d5_rem), .hit(d5_hit), .nbits(d5_nb)
`ifdef SERIAL_MOD_HIT_CNT_EN
    , .hit_cnt(d5_hc)
`endif
  );
  serial_mod_detector #(.DIVISOR(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .valid(valid), .start(start),
    .y(s_y), .rem(s_rem), .hit(s_hit), .nbits(s_nb)
`ifdef SERIAL_MOD_HIT_CNT_EN
    , .hit_cnt(s_hc)
`endif
  );
  serial_mod_detector #(.DIVISOR(2), .CNT_W(8)) u_d2 (
    .clk(clk), .rst(rst), .a(a), .valid(valid), .start(start),
    .y(d2_y), .rem(d2_rem), .hit(d2_hit), .nbits(d2_nb)
`ifdef SERIAL_MOD_HIT_CNT_EN
    , .hit_cnt(d2_hc)
`endif
  );
  serial_mod_detector #(.DIVISOR(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .a(a), .valid(valid), .start(start),
    .y(d1_y), .rem(d1_rem), .hit(d1_hit), .nbits(d1_nb)
`ifdef SERIAL_MOD_HIT_CNT_EN
    , .hit_cnt(d1_hc)
`endif
  );

  task automatic bit_in(input logic b, input logic s);
    @(negedge clk);
    a = b; valid = 1'b1; start = s;
    @(posedge clk);
    #1;
    a = 1'b0; valid = 1'b0; start = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    a = 1'b0; valid = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_only();
    @(negedge clk);
    a = 1'b1; valid = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; a = 1'b1; valid = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; a = 1'b0; valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (d4_y !== 1'b0) begin errors++; $display("FAIL reset_y got=%0d exp=0", d4_y); end
    checks++; if (d4_rem !== 2'd0) begin errors++; $display("FAIL reset_rem got=%0d exp=0", d4_rem); end
    checks++; if (d4_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0d exp=0", d4_hit); end
    checks++; if (d4_nb !== 8'd0) begin errors++; $display("FAIL reset_nbits got=%0d exp=0", d4_nb); end
`ifdef SERIAL_MOD_HIT_CNT_EN
    checks++; if (d4_hc !== 8'd0) begin errors++; $display("FAIL reset_hit_cnt got=%0d exp=0", d4_hc); end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_div4();
    logic [1:0] exp_rem [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
    logic       bits    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bit_in(bits[i], i == 0);
      checks++; if (d4_rem !== exp_rem[i]) begin errors++; $display("FAIL div4_rem[%0d] got=%0d exp=%0d", i, d4_rem, exp_rem[i]); end
      checks++; if (d4_y !== (i == 3)) begin errors++; $display("FAIL div4_y[%0d] got=%0d exp=%0d", i, d4_y, i == 3); end
      checks++; if (d4_hit !== (i == 3)) begin errors++; $display("FAIL div4_hit[%0d] got=%0d exp=%0d", i, d4_hit, i == 3); end
    end
    checks++; if (d4_nb !== 8'd4) begin errors++; $display("FAIL div4_nbits got=%0d exp=4", d4_nb); end
    idle();
    checks++; if (d4_hit !== 1'b0) begin errors++; $display("FAIL div4_hit_idle got=%0d exp=0", d4_hit); end
    checks++; if (d4_y !== 1'b1) begin errors++; $display("FAIL div4_y_idle got=%0d exp=1", d4_y); end
  endtask

  task automatic test_div3();
    logic [1:0] exp_rem [3] = '{2'd1, 2'd0, 2'd0};
    logic       bits    [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bit_in(bits[i], i == 0);
      checks++; if (d3_rem !== exp_rem[i]) begin errors++; $display("FAIL div3_rem[%0d] got=%0d exp=%0d", i, d3_rem, exp_rem[i]); end
      checks++; if (d3_hit !== (i != 0)) begin errors++; $display("FAIL div3_hit[%0d] got=%0d exp=%0d", i, d3_hit, i != 0); end
      checks++; if (d3_y !== (i != 0)) begin errors++; $display("FAIL div3_y[%0d] got=%0d exp=%0d", i, d3_y, i != 0); end
    end
    idle();
    checks++; if (d3_hit !== 1'b0) begin errors++; $display("FAIL div3_hit_idle got=%0d exp=0", d3_hit); end
    checks++; if (d3_y !== 1'b1) begin errors++; $display("FAIL div3_y_idle got=%0d exp=1", d3_y); end
  endtask

  task automatic test_div5_gaps();
    logic [2:0] exp_rem [4] = '{3'd1, 3'd2, 3'd0, 3'd0};
    logic       bits    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bit_in(bits[i], i == 0);
      checks++; if (d5_rem !== exp_rem[i]) begin errors++; $display("FAIL div5_rem[%0d] got=%0d exp=%0d", i, d5_rem, exp_rem[i]); end
      checks++; if (d5_hit !== (i >= 2)) begin errors++; $display("FAIL div5_hit[%0d] got=%0d exp=%0d", i, d5_hit, i >= 2); end
      for (int g = 0; g < 3; g++) begin
        idle();
        checks++; if (d5_rem !== exp_rem[i]) begin errors++; $display("FAIL div5_gap_rem[%0d] got=%0d exp=%0d", i, d5_rem, exp_rem[i]); end
        checks++; if (d5_hit !== 1'b0) begin errors++; $display("FAIL div5_gap_hit[%0d] got=%0d exp=0", i, d5_hit); end
      end
    end
    checks++; if (d5_nb !== 8'd4) begin errors++; $display("FAIL div5_nbits got=%0d exp=4", d5_nb); end
  endtask

  task automatic test_reset_midstream();
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    checks++; if (d4_rem !== 2'd3) begin errors++; $display("FAIL mid_pre_rem got=%0d exp=3", d4_rem); end
    pulse_reset();
    checks++; if ({d4_y, d4_hit, d4_rem, d4_nb} !== 12'd0) begin errors++; $display("FAIL mid_reset_outs got=%0h exp=0", {d4_y, d4_hit, d4_rem, d4_nb}); end
    bit_in(1'b0, 1'b0);
    checks++; if (d4_nb !== 8'd1) begin errors++; $display("FAIL mid_nbits1 got=%0d exp=1", d4_nb); end
    checks++; if (d4_y !== 1'b1) begin errors++; $display("FAIL mid_y1 got=%0d exp=1", d4_y); end
    bit_in(1'b0, 1'b0);
    checks++; if (d4_y !== 1'b1) begin errors++; $display("FAIL mid_y2 got=%0d exp=1", d4_y); end
    checks++; if (d4_nb !== 8'd2) begin errors++; $display("FAIL mid_nbits2 got=%0d exp=2", d4_nb); end
    checks++; if (d4_rem !== 2'd0) begin errors++; $display("FAIL mid_rem2 got=%0d exp=0", d4_rem); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_rem [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [1:0] exp_nb  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1, i == 0);
      checks++; if (s_rem !== exp_rem[i]) begin errors++; $display("FAIL sat_rem[%0d] got=%0d exp=%0d", i, s_rem, exp_rem[i]); end
      checks++; if (s_nb !== exp_nb[i]) begin errors++; $display("FAIL sat_nbits[%0d] got=%0d exp=%0d", i, s_nb, exp_nb[i]); end
    end
  endtask

  task automatic test_div1();
    start_only();
    checks++; if (d1_y !== 1'b0) begin errors++; $display("FAIL div1_y_start got=%0d exp=0", d1_y); end
    checks++; if (d1_nb !== 8'd0) begin errors++; $display("FAIL div1_nbits_start got=%0d exp=0", d1_nb); end
    bit_in(1'b1, 1'b0);
    checks++; if (d1_rem !== 1'b0) begin errors++; $display("FAIL div1_rem got=%0d exp=0", d1_rem); end
    checks++; if (d1_y !== 1'b1) begin errors++; $display("FAIL div1_y got=%0d exp=1", d1_y); end
    checks++; if (d1_hit !== 1'b1) begin errors++; $display("FAIL div1_hit got=%0d exp=1", d1_hit); end
  endtask

  task automatic test_hit_cnt();
    logic       bits [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       sts  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [0:0] erem [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ehc  [4] = '{8'd1, 8'd2, 8'd2, 8'd3};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bit_in(bits[i], sts[i]);
      checks++; if (d2_rem !== erem[i]) begin errors++; $display("FAIL d2_rem[%0d] got=%0d exp=%0d", i, d2_rem, erem[i]); end
      checks++; if (d2_hit !== (i != 2)) begin errors++; $display("FAIL d2_hit[%0d] got=%0d exp=%0d", i, d2_hit, i != 2); end
`ifdef SERIAL_MOD_HIT_CNT_EN
      checks++; if (d2_hc !== ehc[i]) begin errors++; $display("FAIL d2_hit_cnt[%0d] got=%0d exp=%0d", i, d2_hc, ehc[i]); end
`else
      if (ehc[i] == 8'd0) $display("note: unexpected table entry");
`endif
    end
    start_only();
    checks++; if (d2_y !== 1'b0) begin errors++; $display("FAIL d2_y_start got=%0d exp=0", d2_y); end
    checks++; if (d2_nb !== 8'd0) begin errors++; $display("FAIL d2_nbits_start got=%0d exp=0", d2_nb); end
`ifdef SERIAL_MOD_HIT_CNT_EN
    checks++; if (d2_hc !== 8'd3) begin errors++; $display("FAIL d2_hit_cnt_start got=%0d exp=3", d2_hc); end
`endif
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div3();
    test_div5_gaps();
    test_reset_midstream();
    test_saturation();
    test_div1();
    test_hit_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
